sap_sequencer: RTL and testbench

- Controller/sequencer (CNTRL slot, sel=4'h7) for the 8-bit bus computer: PC, MAR, EEPROM memory, IR, accumulator, B register, add/sub ALU, output register.
- Steps each instruction through fetch/execute T-states and drives one control word per cycle.
- Holds in wait states while the I2C EEPROM completes a read. Bounds each wait with a timeout that faults the machine.

---
 rtl/sap_pkg.sv | 55 +++++
 rtl/sap_sequencer_if.sv | 30 +++
 rtl/sap_ctrl_decode.sv | 57 +++++
 rtl/sap_sequencer.sv | 96 +++++++++
 tb/tb_sap_sequencer.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/sap_pkg.sv
// Shared types for the SAP-style bus computer sequencer: opcodes, T-states,
// and the 13-bit control word driven onto the bus each cycle.
package sap_pkg;

  typedef enum logic [3:0] {
    OP_LDA = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    S_T1    = 3'd0,
    S_T2    = 3'd1,
    S_T3    = 3'd2,
    S_T4    = 3'd3,
    S_T5    = 3'd4,
    S_T6    = 3'd5,
    S_HALT  = 3'd6,
    S_FAULT = 3'd7
  } state_t;

  typedef struct packed {
    logic pc_oe;
    logic pc_inc;
    logic mar_we;
    logic mem_rd;
    logic mem_oe;
    logic ir_we;
    logic ir_oe;
    logic acc_we;
    logic acc_oe;
    logic b_we;
    logic alu_oe;
    logic alu_sub;
    logic out_we;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_IDLE = '0;

  // Externally visible T-state number; HALT and FAULT report 0.
  function automatic logic [2:0] t_state_of(input state_t s);
    case (s)
      S_T1:    return 3'd1;
      S_T2:    return 3'd2;
      S_T3:    return 3'd3;
      S_T4:    return 3'd4;
      S_T5:    return 3'd5;
      S_T6:    return 3'd6;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/sap_sequencer_if.sv
// Sequencer-to-datapath signal bundle: run/opcode/mem_done in, control word
// and status out. The sequencer uses the master view, the datapath the slave.
interface sap_sequencer_if;

  logic       run;
  logic [3:0] ir_opcode;
  logic       mem_done;

  logic pc_oe, pc_inc, mar_we, mem_rd, mem_oe, ir_we, ir_oe;
  logic acc_we, acc_oe, b_we, alu_oe, alu_sub, out_we;

  logic [2:0] t_state;
  logic       halted;
  logic       fault;

  modport master (
    input  run, ir_opcode, mem_done,
    output pc_oe, pc_inc, mar_we, mem_rd, mem_oe, ir_we, ir_oe,
    output acc_we, acc_oe, b_we, alu_oe, alu_sub, out_we,
    output t_state, halted, fault
  );

  modport slave (
    output run, ir_opcode, mem_done,
    input  pc_oe, pc_inc, mar_we, mem_rd, mem_oe, ir_we, ir_oe,
    input  acc_we, acc_oe, b_we, alu_oe, alu_sub, out_we,
    input  t_state, halted, fault
  );

endinterface

// File: rtl/sap_ctrl_decode.sv
// Combinational control-word decode from (state, opcode, mem_done). The wait
// states are Mealy on mem_done so the read data is latched in the done cycle.
module sap_ctrl_decode
  import sap_pkg::*;
(
  input  state_t     state_i,
  input  logic [3:0] opcode_i,
  input  logic       mem_done_i,
  output ctrl_word_t cw_o
);

  always_comb begin
    cw_o = CTRL_IDLE;
    case (state_i)
      S_T1: begin
        cw_o.pc_oe  = 1'b1;
        cw_o.mar_we = 1'b1;
      end
      S_T2: cw_o.pc_inc = 1'b1;
      S_T3: begin
        cw_o.mem_rd = 1'b1;
        if (mem_done_i) begin
          cw_o.mem_oe = 1'b1;
          cw_o.ir_we  = 1'b1;
        end
      end
      S_T4: begin
        case (opcode_i)
          OP_LDA, OP_ADD, OP_SUB: begin
            cw_o.ir_oe  = 1'b1;
            cw_o.mar_we = 1'b1;
          end
          OP_OUT: begin
            cw_o.acc_oe = 1'b1;
            cw_o.out_we = 1'b1;
          end
          default: cw_o = CTRL_IDLE;
        endcase
      end
      S_T5: begin
        cw_o.mem_rd = 1'b1;
        if (mem_done_i) begin
          cw_o.mem_oe = 1'b1;
          if (opcode_i == OP_LDA) cw_o.acc_we = 1'b1;
          else                    cw_o.b_we   = 1'b1;
        end
      end
      S_T6: begin
        cw_o.alu_oe  = 1'b1;
        cw_o.acc_we  = 1'b1;
        cw_o.alu_sub = (opcode_i == OP_SUB);
      end
      default: cw_o = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/sap_sequencer.sv
// Instruction sequencer: T-state register, bounded memory-wait counter and
// next-state logic. run is only consulted in T1; T1 without run emits nothing.
module sap_sequencer
  import sap_pkg::*;
#(
  parameter int MEM_TIMEOUT = 1023,
  parameter int TW          = 16
) (
  input logic CLK,
  input logic RESET,
  sap_sequencer_if.master bus
);

  localparam logic [TW-1:0] WAIT_LAST = TW'(MEM_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [2:0]    t_state_q;
  logic          halted_q, fault_q;
  ctrl_word_t    cw;
  ctrl_word_t    cw_gated;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_T1: if (bus.run) state_d = S_T2;
      S_T2: state_d = S_T3;
      S_T3, S_T5: begin
        // A done pulse on the last allowed cycle still counts as success.
        if (bus.mem_done) begin
          if (state_q == S_T3)                state_d = S_T4;
          else if (bus.ir_opcode == OP_LDA)   state_d = S_T1;
          else                                state_d = S_T6;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_T4: begin
        case (bus.ir_opcode)
          OP_LDA, OP_ADD, OP_SUB: state_d = S_T5;
          OP_HLT:                 state_d = S_HALT;
          default:                state_d = S_T1;
        endcase
      end
      S_T6:    state_d = S_T1;
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_T1;
      cnt_q     <= '0;
      t_state_q <= 3'd1;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      t_state_q <= t_state_of(state_d);
      halted_q  <= (state_d == S_HALT);
      fault_q   <= (state_d == S_FAULT);
    end
  end

  sap_ctrl_decode u_decode (
    .state_i    (state_q),
    .opcode_i   (bus.ir_opcode),
    .mem_done_i (bus.mem_done),
    .cw_o       (cw)
  );

  assign cw_gated = (state_q == S_T1 && !bus.run) ? CTRL_IDLE : cw;

  assign bus.pc_oe   = cw_gated.pc_oe;
  assign bus.pc_inc  = cw_gated.pc_inc;
  assign bus.mar_we  = cw_gated.mar_we;
  assign bus.mem_rd  = cw_gated.mem_rd;
  assign bus.mem_oe  = cw_gated.mem_oe;
  assign bus.ir_we   = cw_gated.ir_we;
  assign bus.ir_oe   = cw_gated.ir_oe;
  assign bus.acc_we  = cw_gated.acc_we;
  assign bus.acc_oe  = cw_gated.acc_oe;
  assign bus.b_we    = cw_gated.b_we;
  assign bus.alu_oe  = cw_gated.alu_oe;
  assign bus.alu_sub = cw_gated.alu_sub;
  assign bus.out_we  = cw_gated.out_we;

  assign bus.t_state = t_state_q;
  assign bus.halted  = halted_q;
  assign bus.fault   = fault_q;

endmodule

// File: tb/tb_sap_sequencer.sv
// Directed bench for sap_sequencer with MEM_TIMEOUT=8: instruction flows,
// memory stalls, timeout fault, reset mid-wait and single-shot run.
module tb_sap_sequencer;

  localparam logic [12:0] PC_OE   = 13'h1000;
  localparam logic [12:0] PC_INC  = 13'h0800;
  localparam logic [12:0] MAR_WE  = 13'h0400;
  localparam logic [12:0] MEM_RD  = 13'h0200;
  localparam logic [12:0] MEM_OE  = 13'h0100;
  localparam logic [12:0] IR_WE   = 13'h0080;
  localparam logic [12:0] IR_OE   = 13'h0040;
  localparam logic [12:0] ACC_WE  = 13'h0020;
  localparam logic [12:0] ACC_OE  = 13'h0010;
  localparam logic [12:0] B_WE    = 13'h0008;
  localparam logic [12:0] ALU_OE  = 13'h0004;
  localparam logic [12:0] ALU_SUB = 13'h0002;
  localparam logic [12:0] OUT_WE  = 13'h0001;
  localparam logic [12:0] NONE    = 13'h0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  sap_sequencer_if bus ();

  sap_sequencer #(.MEM_TIMEOUT(8), .TW(16)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  function automatic logic [12:0] cw();
    return {bus.pc_oe, bus.pc_inc, bus.mar_we, bus.mem_rd, bus.mem_oe,
            bus.ir_we, bus.ir_oe, bus.acc_we, bus.acc_oe, bus.b_we,
            bus.alu_oe, bus.alu_sub, bus.out_we};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle: apply inputs, check state number and control word, advance.
  task automatic cyc(input string tag, input logic run, input logic [3:0] op,
                     input logic done, input logic [2:0] exp_t, input logic [12:0] exp_cw);
    bus.run       = run;
    bus.ir_opcode = op;
    bus.mem_done  = done;
    #1;
    chk({tag, ".t"},  {29'd0, bus.t_state}, {29'd0, exp_t});
    chk({tag, ".cw"}, {19'd0, cw()},        {19'd0, exp_cw});
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      n_checks++;
      assert ($onehot0({bus.pc_oe, bus.mem_oe, bus.ir_oe, bus.acc_oe, bus.alu_oe})) else begin
        n_errors++;
        $error("FAIL bus_driver: observed %05b expected at most one high",
               {bus.pc_oe, bus.mem_oe, bus.ir_oe, bus.acc_oe, bus.alu_oe});
      end
    end
  end

  initial begin
    bus.run = 1'b0;
    bus.ir_opcode = 4'h0;
    bus.mem_done = 1'b0;
    tick();
    do_reset();

    // Reset state
    #1;
    chk("rst.t",      {29'd0, bus.t_state}, 32'd1);
    chk("rst.halted", {31'd0, bus.halted},  32'd0);
    chk("rst.fault",  {31'd0, bus.fault},   32'd0);
    chk("rst.cw",     {19'd0, cw()},        32'd0);
    tick();

    // LDA with 3-cycle memory reads
    cyc("lda.t1", 1, 4'h0, 0, 1, PC_OE | MAR_WE);
    cyc("lda.t2", 1, 4'h0, 0, 2, PC_INC);
    cyc("lda.t3a", 1, 4'h0, 0, 3, MEM_RD);
    cyc("lda.t3b", 1, 4'h0, 0, 3, MEM_RD);
    cyc("lda.t3c", 1, 4'h0, 1, 3, MEM_RD | MEM_OE | IR_WE);
    cyc("lda.t4", 1, 4'h0, 0, 4, IR_OE | MAR_WE);
    cyc("lda.t5a", 1, 4'h0, 0, 5, MEM_RD);
    cyc("lda.t5b", 1, 4'h0, 0, 5, MEM_RD);
    cyc("lda.t5c", 1, 4'h0, 1, 5, MEM_RD | MEM_OE | ACC_WE);

    // ADD then SUB, immediate memory
    cyc("add.t1", 1, 4'h1, 0, 1, PC_OE | MAR_WE);
    cyc("add.t2", 1, 4'h1, 0, 2, PC_INC);
    cyc("add.t3", 1, 4'h1, 1, 3, MEM_RD | MEM_OE | IR_WE);
    cyc("add.t4", 1, 4'h1, 0, 4, IR_OE | MAR_WE);
    cyc("add.t5", 1, 4'h1, 1, 5, MEM_RD | MEM_OE | B_WE);
    cyc("add.t6", 1, 4'h1, 0, 6, ALU_OE | ACC_WE);
    cyc("sub.t1", 1, 4'h2, 0, 1, PC_OE | MAR_WE);
    cyc("sub.t2", 1, 4'h2, 0, 2, PC_INC);
    cyc("sub.t3", 1, 4'h2, 1, 3, MEM_RD | MEM_OE | IR_WE);
    cyc("sub.t4", 1, 4'h2, 0, 4, IR_OE | MAR_WE);
    cyc("sub.t5", 1, 4'h2, 1, 5, MEM_RD | MEM_OE | B_WE);
    cyc("sub.t6", 1, 4'h2, 0, 6, ALU_OE | ACC_WE | ALU_SUB);

    // NOP (unassigned opcode) ends after T4
    cyc("nop.t1", 1, 4'h5, 0, 1, PC_OE | MAR_WE);
    cyc("nop.t2", 1, 4'h5, 0, 2, PC_INC);
    cyc("nop.t3", 1, 4'h5, 1, 3, MEM_RD | MEM_OE | IR_WE);
    cyc("nop.t4", 1, 4'h5, 0, 4, NONE);

    // OUT then HLT
    cyc("out.t1", 1, 4'hE, 0, 1, PC_OE | MAR_WE);
    cyc("out.t2", 1, 4'hE, 0, 2, PC_INC);
    cyc("out.t3", 1, 4'hE, 1, 3, MEM_RD | MEM_OE | IR_WE);
    cyc("out.t4", 1, 4'hE, 0, 4, ACC_OE | OUT_WE);
    cyc("hlt.t1", 1, 4'hF, 0, 1, PC_OE | MAR_WE);
    cyc("hlt.t2", 1, 4'hF, 0, 2, PC_INC);
    cyc("hlt.t3", 1, 4'hF, 1, 3, MEM_RD | MEM_OE | IR_WE);
    cyc("hlt.t4", 1, 4'hF, 0, 4, NONE);
    for (int i = 0; i < 100; i++) begin
      chk("halt.halted", {31'd0, bus.halted}, 32'd1);
      cyc("halt.hold", 1, 4'hF, i[0], 0, NONE);
    end
    bus.run = 1'b0;
    do_reset();
    #1;
    chk("halt_rst.t",      {29'd0, bus.t_state}, 32'd1);
    chk("halt_rst.halted", {31'd0, bus.halted},  32'd0);
    tick();

    // Timeout: 8 wait cycles without mem_done, then FAULT
    cyc("to.t1", 1, 4'h5, 0, 1, PC_OE | MAR_WE);
    cyc("to.t2", 1, 4'h5, 0, 2, PC_INC);
    for (int i = 0; i < 8; i++) cyc("to.t3", 1, 4'h5, 0, 3, MEM_RD);
    chk("to.fault", {31'd0, bus.fault}, 32'd1);
    cyc("to.f0", 1, 4'h5, 1, 0, NONE);
    cyc("to.f1", 1, 4'h5, 1, 0, NONE);
    chk("to.fault_held", {31'd0, bus.fault}, 32'd1);
    bus.run = 1'b0;
    do_reset();
    #1;
    chk("to_rst.fault", {31'd0, bus.fault},   32'd0);
    chk("to_rst.t",     {29'd0, bus.t_state}, 32'd1);
    tick();

    // Done on the last allowed wait cycle wins over the timeout
    cyc("dw.t1", 1, 4'h5, 0, 1, PC_OE | MAR_WE);
    cyc("dw.t2", 1, 4'h5, 0, 2, PC_INC);
    for (int i = 0; i < 7; i++) cyc("dw.t3", 1, 4'h5, 0, 3, MEM_RD);
    cyc("dw.t3last", 1, 4'h5, 1, 3, MEM_RD | MEM_OE | IR_WE);
    cyc("dw.t4", 0, 4'h5, 0, 4, NONE);
    chk("dw.fault", {31'd0, bus.fault}, 32'd0);
    cyc("dw.park", 0, 4'h5, 0, 1, NONE);

    // RESET during the T5 wait; late mem_done must not write anything
    cyc("rw.t1", 1, 4'h0, 0, 1, PC_OE | MAR_WE);
    cyc("rw.t2", 0, 4'h0, 0, 2, PC_INC);
    cyc("rw.t3", 0, 4'h0, 1, 3, MEM_RD | MEM_OE | IR_WE);
    cyc("rw.t4", 0, 4'h0, 0, 4, IR_OE | MAR_WE);
    cyc("rw.t5", 0, 4'h0, 0, 5, MEM_RD);
    do_reset();
    cyc("rw.late", 0, 4'h0, 1, 1, NONE);
    cyc("rw.after", 0, 4'h0, 1, 1, NONE);

    // run pulsed for one cycle: one OUT instruction, then park in T1
    for (int i = 0; i < 3; i++) cyc("rp.idle", 0, 4'hE, 0, 1, NONE);
    cyc("rp.t1", 1, 4'hE, 0, 1, PC_OE | MAR_WE);
    cyc("rp.t2", 0, 4'hE, 0, 2, PC_INC);
    cyc("rp.t3", 0, 4'hE, 1, 3, MEM_RD | MEM_OE | IR_WE);
    cyc("rp.t4", 0, 4'hE, 0, 4, ACC_OE | OUT_WE);
    for (int i = 0; i < 3; i++) cyc("rp.park", 0, 4'hE, i[0], 1, NONE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
